// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the MIPS31 ALU control interface: the 4-bit ALU
// control codes, the opcode/funct values decoded by the issue stage, and the
// issue payload struct carried from ID to EX.
// ---------------------------------------------------------------------------
package alu_pkg;

    // ALU control codes; 0000 is reserved to mark an undecodable instruction.
    localparam logic [3:0] ALU_INVALID = 4'b0000;
    localparam logic [3:0] ALU_MOVN    = 4'b0001;
    localparam logic [3:0] ALU_ADD     = 4'b0010;
    localparam logic [3:0] ALU_ADDU    = 4'b0011;
    localparam logic [3:0] ALU_SUB     = 4'b0100;
    localparam logic [3:0] ALU_SUBU    = 4'b0101;
    localparam logic [3:0] ALU_AND     = 4'b0110;
    localparam logic [3:0] ALU_OR      = 4'b0111;
    localparam logic [3:0] ALU_XOR     = 4'b1000;
    localparam logic [3:0] ALU_NOR     = 4'b1001;
    localparam logic [3:0] ALU_SLT     = 4'b1010;
    localparam logic [3:0] ALU_SLTU    = 4'b1011;
    localparam logic [3:0] ALU_SRL     = 4'b1100;
    localparam logic [3:0] ALU_SRA     = 4'b1101;
    localparam logic [3:0] ALU_SLL     = 4'b1110;
    localparam logic [3:0] ALU_LUI     = 4'b1111;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct values
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_MOVN = 6'h0B;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [31:0] opr1;
        logic [31:0] opr2;
        logic [4:0]  dest;
        logic        regWrite;
        logic        illegal;
    } issuePayload_t;

    localparam int ISSUE_W = $bits(issuePayload_t);

endpackage

// File: rtl/alu_issue_decode.sv
// ---------------------------------------------------------------------------
// alu_issue_decode
// Purely combinational decode of one instruction plus its register-file read
// data into the ALU issue payload (packed issuePayload_t).
// Ports:
//   instr   in  32        instruction word
//   rsData  in  32        GPR[rs]
//   rtData  in  32        GPR[rt]
//   payload out ISSUE_W   packed issuePayload_t
// ---------------------------------------------------------------------------
module alu_issue_decode
    import alu_pkg::*;
(
    input  logic [31:0]        instr,
    input  logic [31:0]        rsData,
    input  logic [31:0]        rtData,
    output logic [ISSUE_W-1:0] payload
);

    logic [5:0]    opcode;
    logic [5:0]    funct;
    logic [31:0]   immSext;
    logic [31:0]   immZext;
    logic [31:0]   shamtOpr;
    logic [31:0]   varShOpr;
    logic          writes;
    logic          legal;
    issuePayload_t p;

    // The rs register number arrives already resolved as rsData.
    logic unusedRsField;
    assign unusedRsField = ^instr[25:21];

    assign opcode   = instr[31:26];
    assign funct    = instr[5:0];
    assign immSext  = {{16{instr[15]}}, instr[15:0]};
    assign immZext  = {16'h0000, instr[15:0]};
    assign shamtOpr = {27'b0, instr[10:6]};
    // The ALU shifts by the whole 32-bit opr1, so only rs[4:0] may pass.
    assign varShOpr = {27'b0, rsData[4:0]};

    always_comb begin
        p        = '0;
        p.opr1   = rsData;
        p.opr2   = rtData;
        p.dest   = instr[15:11];
        writes   = 1'b1;
        legal    = 1'b1;
        if (opcode == OP_RTYPE) begin
            case (funct)
                FN_ADD:  p.ctrl = ALU_ADD;
                FN_ADDU: p.ctrl = ALU_ADDU;
                FN_SUB:  p.ctrl = ALU_SUB;
                FN_SUBU: p.ctrl = ALU_SUBU;
                FN_AND:  p.ctrl = ALU_AND;
                FN_OR:   p.ctrl = ALU_OR;
                FN_XOR:  p.ctrl = ALU_XOR;
                FN_NOR:  p.ctrl = ALU_NOR;
                FN_SLT:  p.ctrl = ALU_SLT;
                FN_SLTU: p.ctrl = ALU_SLTU;
                FN_MOVN: p.ctrl = ALU_MOVN;
                FN_SLL:  begin p.ctrl = ALU_SLL; p.opr1 = shamtOpr; end
                FN_SRL:  begin p.ctrl = ALU_SRL; p.opr1 = shamtOpr; end
                FN_SRA:  begin p.ctrl = ALU_SRA; p.opr1 = shamtOpr; end
                FN_SLLV: begin p.ctrl = ALU_SLL; p.opr1 = varShOpr; end
                FN_SRLV: begin p.ctrl = ALU_SRL; p.opr1 = varShOpr; end
                FN_SRAV: begin p.ctrl = ALU_SRA; p.opr1 = varShOpr; end
                default: legal = 1'b0;
            endcase
        end else begin
            p.dest = instr[20:16];
            p.opr2 = immSext;
            case (opcode)
                OP_ADDI:  p.ctrl = ALU_ADD;
                OP_ADDIU: p.ctrl = ALU_ADDU;
                OP_SLTI:  p.ctrl = ALU_SLT;
                OP_SLTIU: p.ctrl = ALU_SLTU;
                OP_ANDI:  begin p.ctrl = ALU_AND; p.opr2 = immZext; end
                OP_ORI:   begin p.ctrl = ALU_OR;  p.opr2 = immZext; end
                OP_XORI:  begin p.ctrl = ALU_XOR; p.opr2 = immZext; end
                OP_LUI:   begin p.ctrl = ALU_LUI; p.opr2 = immZext; end
                OP_LW:    p.ctrl = ALU_ADDU;
                OP_SW:    begin p.ctrl = ALU_ADDU; writes = 1'b0; end
                default:  legal = 1'b0;
            endcase
        end
        if (!legal) begin
            p         = '0;
            p.illegal = 1'b1;
        end else begin
            p.regWrite = writes & (p.dest != 5'd0);
        end
    end

    assign payload = p;

endmodule

// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
// ID->EX issue stage: decodes the instruction through alu_issue_decode and
// registers the payload toward EX behind a valid/ready handshake.
// Optional feature macro: ALU_ISSUE_SKID_EN
//   defined   : 2-entry buffer (output register + skid), in_ready registered
//   undefined : single output register, in_ready = !out_valid | out_ready
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   in_valid/in_ready        ID handshake; in_instr, in_rs_data, in_rt_data
//   flush                    synchronous squash of all held entries
//   out_valid/out_ready      EX handshake
//   out_alu_ctrl, out_opr1, out_opr2, out_dest, out_reg_write, out_illegal
//   illegal_cnt              saturating count of accepted illegal instrs
// ---------------------------------------------------------------------------
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_rs_data,
    input  logic [31:0]      in_rt_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_alu_ctrl,
    output logic [31:0]      out_opr1,
    output logic [31:0]      out_opr2,
    output logic [4:0]       out_dest,
    output logic             out_reg_write,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    logic [ISSUE_W-1:0] decoded;
    issuePayload_t      decPayload;
    issuePayload_t      outPayload;
    logic               outValid;
    logic               accept;
    logic [CNT_W-1:0]   illegalCnt;

    alu_issue_decode uDecode (
        .instr   (in_instr),
        .rsData  (in_rs_data),
        .rtData  (in_rt_data),
        .payload (decoded)
    );

    assign decPayload = issuePayload_t'(decoded);
    // flush wins over a same-cycle input.
    assign accept     = in_valid & in_ready & ~flush;

`ifdef ALU_ISSUE_SKID_EN
    issuePayload_t skidPayload;
    logic          skidValid;

    // Ready only depends on state, so there is no comb path from out_ready.
    assign in_ready = ~skidValid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outValid    <= 1'b0;
            outPayload  <= '0;
            skidValid   <= 1'b0;
            skidPayload <= '0;
        end else if (flush) begin
            outValid  <= 1'b0;
            skidValid <= 1'b0;
        end else if (outValid && !out_ready) begin
            // Output stalled: a new entry can only land in the skid slot,
            // which is empty whenever accept is possible.
            if (accept) begin
                skidPayload <= decPayload;
                skidValid   <= 1'b1;
            end
        end else if (skidValid) begin
            // Output free: older skid entry goes first; in_ready was low.
            outPayload <= skidPayload;
            outValid   <= 1'b1;
            skidValid  <= 1'b0;
        end else begin
            outValid <= accept;
            if (accept) outPayload <= decPayload;
        end
    end
`else
    assign in_ready = ~outValid | out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outValid   <= 1'b0;
            outPayload <= '0;
        end else if (flush) begin
            outValid <= 1'b0;
        end else if (accept) begin
            outValid   <= 1'b1;
            outPayload <= decPayload;
        end else if (out_ready) begin
            outValid <= 1'b0;
        end
    end
`endif

    // Counter survives flush; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegalCnt <= '0;
        end else if (accept && decPayload.illegal && !(&illegalCnt)) begin
            illegalCnt <= illegalCnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign out_valid     = outValid;
    assign out_alu_ctrl  = outPayload.ctrl;
    assign out_opr1      = outPayload.opr1;
    assign out_opr2      = outPayload.opr2;
    assign out_dest      = outPayload.dest;
    assign out_reg_write = outPayload.regWrite;
    assign out_illegal   = outPayload.illegal;
    assign illegal_cnt   = illegalCnt;

endmodule

// File: tb/tb_alu_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_stage
// Self-checking bench for alu_issue_stage: directed vector table, hand-written
// backpressure / flush / reset sequences, and randomized traffic compared to
// a queue-based reference model. Works with ALU_ISSUE_SKID_EN on or off.
// ---------------------------------------------------------------------------
module tb_alu_issue_stage;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef ALU_ISSUE_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_instr = '0;
    logic [31:0]      in_rs_data = '0;
    logic [31:0]      in_rt_data = '0;
    logic             flush = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [3:0]       out_alu_ctrl;
    logic [31:0]      out_opr1;
    logic [31:0]      out_opr2;
    logic [4:0]       out_dest;
    logic             out_reg_write;
    logic             out_illegal;
    logic [CNT_W-1:0] illegal_cnt;

    always #5 clk = ~clk;

    alu_issue_stage #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_alu_ctrl(out_alu_ctrl), .out_opr1(out_opr1), .out_opr2(out_opr2),
        .out_dest(out_dest), .out_reg_write(out_reg_write),
        .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
    );

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] opr1;
        logic [31:0] opr2;
        logic [4:0]  dest;
        logic        rw;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] rs;
        logic [31:0] rt;
        exp_t        e;
        int          cnt;
    } vec_t;

    exp_t q[$];
    int   modelCnt = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference decode, straight from the instruction-set rules.
    function automatic exp_t refDecode(logic [31:0] ins, logic [31:0] rs, logic [31:0] rt);
        exp_t        e;
        logic [5:0]  op = ins[31:26];
        logic [5:0]  fn = ins[5:0];
        logic [31:0] se = {{16{ins[15]}}, ins[15:0]};
        logic [31:0] ze = {16'h0, ins[15:0]};
        logic [31:0] sh = 32'(ins[10:6]);
        int          code = 0;
        bit          wr = 1;
        e.opr1 = rs; e.opr2 = rt; e.dest = ins[15:11];
        if (op == 0) begin
            case (fn)
                6'h20: code = 2;   6'h21: code = 3;   6'h22: code = 4;
                6'h23: code = 5;   6'h24: code = 6;   6'h25: code = 7;
                6'h26: code = 8;   6'h27: code = 9;   6'h2A: code = 10;
                6'h2B: code = 11;  6'h0B: code = 1;
                6'h00: begin code = 14; e.opr1 = sh; end
                6'h02: begin code = 12; e.opr1 = sh; end
                6'h03: begin code = 13; e.opr1 = sh; end
                6'h04: begin code = 14; e.opr1 = rs % 32; end
                6'h06: begin code = 12; e.opr1 = rs % 32; end
                6'h07: begin code = 13; e.opr1 = rs % 32; end
                default: code = 0;
            endcase
        end else begin
            e.dest = ins[20:16];
            e.opr2 = se;
            case (op)
                6'h08: code = 2;   6'h09: code = 3;
                6'h0A: code = 10;  6'h0B: code = 11;
                6'h0C: begin code = 6;  e.opr2 = ze; end
                6'h0D: begin code = 7;  e.opr2 = ze; end
                6'h0E: begin code = 8;  e.opr2 = ze; end
                6'h0F: begin code = 15; e.opr2 = ze; end
                6'h23: code = 3;
                6'h2B: begin code = 3; wr = 0; end
                default: code = 0;
            endcase
        end
        if (code == 0) begin
            e.ctrl = 0; e.opr1 = 0; e.opr2 = 0; e.dest = 0; e.rw = 0; e.ill = 1;
        end else begin
            e.ctrl = 4'(code);
            e.rw   = wr && (e.dest != 0);
            e.ill  = 0;
        end
        return e;
    endfunction

    task automatic checkOut();
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk("out_alu_ctrl", 32'(out_alu_ctrl), 32'(q[0].ctrl));
            chk("out_opr1", out_opr1, q[0].opr1);
            chk("out_opr2", out_opr2, q[0].opr2);
            chk("out_dest", 32'(out_dest), 32'(q[0].dest));
            chk("out_reg_write", 32'(out_reg_write), 32'(q[0].rw));
            chk("out_illegal", 32'(out_illegal), 32'(q[0].ill));
        end
        chk("illegal_cnt", 32'(illegal_cnt), 32'(modelCnt));
    endtask

    // One clock: drive at negedge, check in_ready, advance model, check outputs.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] rs,
                        input logic [31:0] rt, input logic fl, input logic rdy,
                        output logic accepted);
        bit   expReady;
        exp_t d;
        in_valid = v; in_instr = ins; in_rs_data = rs; in_rt_data = rt;
        flush = fl; out_ready = rdy;
        #1;
        expReady = (DEPTH == 2) ? (q.size() < 2) : (q.size() == 0 || rdy);
        chk("in_ready", 32'(in_ready), 32'(expReady));
        accepted = v && expReady && !fl;
        d = refDecode(ins, rs, rt);
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (q.size() > 0 && rdy) void'(q.pop_front());
            if (accepted) begin
                q.push_back(d);
                if (d.ill && modelCnt < CNT_MAX) modelCnt++;
            end
        end
        #1;
        checkOut();
        @(negedge clk);
    endtask

    function automatic vec_t mk(logic [31:0] ins, logic [31:0] rs, logic [31:0] rt,
                                logic [3:0] c, logic [31:0] o1, logic [31:0] o2,
                                logic [4:0] d, logic rw, logic ill, int cnt);
        vec_t r;
        r.ins = ins; r.rs = rs; r.rt = rt;
        r.e.ctrl = c; r.e.opr1 = o1; r.e.opr2 = o2; r.e.dest = d;
        r.e.rw = rw; r.e.ill = ill; r.cnt = cnt;
        return r;
    endfunction

    logic [5:0] opPick[14] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0B,
                               6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h3F};
    logic [5:0] fnPick[20] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h0B,
                               6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                               6'h27, 6'h2A, 6'h2B, 6'h01, 6'h3F, 6'h15};

    initial begin
        vec_t        tbl[$];
        logic        acc;
        int          nAcc;
        logic [31:0] ins;
        logic [31:0] rsv;

        // Reset state
        #12;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_ctrl", 32'(out_alu_ctrl), 0);
        chk("rst_opr1", out_opr1, 0);
        chk("rst_opr2", out_opr2, 0);
        chk("rst_dest", 32'({out_dest, out_reg_write, out_illegal}), 0);
        chk("rst_illegal_cnt", 32'(illegal_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 1);

        // Directed decode table
        tbl.push_back(mk(32'hFC221820, 5, 7, 4'h0, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(32'hFC221820, 5, 7, 4'h0, 0, 0, 0, 0, 1, 2));
        tbl.push_back(mk(32'h00221820, 5, 7, 4'h2, 5, 7, 3, 1, 0, 2));
        tbl.push_back(mk(32'h00222004, 32'h123, 1, 4'hE, 3, 1, 4, 1, 0, 2));
        tbl.push_back(mk(32'h00222006, 32'hFFFFFFE5, 9, 4'hC, 5, 9, 4, 1, 0, 2));
        tbl.push_back(mk(32'h00062FC3, 32'hDEAD, 32'h80000000, 4'hD, 31, 32'h80000000, 5, 1, 0, 2));
        tbl.push_back(mk(32'h30278000, 32'hFFFF, 32'h55, 4'h6, 32'hFFFF, 32'h8000, 7, 1, 0, 2));
        tbl.push_back(mk(32'h20288000, 32'h10, 32'h55, 4'h2, 32'h10, 32'hFFFF8000, 8, 1, 0, 2));
        tbl.push_back(mk(32'h3C091234, 0, 32'h77, 4'hF, 0, 32'h1234, 9, 1, 0, 2));
        tbl.push_back(mk(32'h0022500B, 3, 0, 4'h1, 3, 0, 10, 1, 0, 2));
        tbl.push_back(mk(32'hAC220004, 32'h100, 32'h99, 4'h3, 32'h100, 4, 2, 0, 0, 2));
        tbl.push_back(mk(32'h8C20FFFC, 32'h40, 32'h99, 4'h3, 32'h40, 32'hFFFFFFFC, 0, 0, 0, 2));
        tbl.push_back(mk(32'h0022183F, 5, 7, 4'h0, 0, 0, 0, 0, 1, 3));
        @(negedge clk);
        foreach (tbl[i]) begin
            step(1'b1, tbl[i].ins, tbl[i].rs, tbl[i].rt, 1'b0, 1'b1, acc);
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 1);
            chk($sformatf("tbl%0d_ctrl", i), 32'(out_alu_ctrl), 32'(tbl[i].e.ctrl));
            chk($sformatf("tbl%0d_opr1", i), out_opr1, tbl[i].e.opr1);
            chk($sformatf("tbl%0d_opr2", i), out_opr2, tbl[i].e.opr2);
            chk($sformatf("tbl%0d_dest", i), 32'(out_dest), 32'(tbl[i].e.dest));
            chk($sformatf("tbl%0d_rw", i), 32'(out_reg_write), 32'(tbl[i].e.rw));
            chk($sformatf("tbl%0d_ill", i), 32'(out_illegal), 32'(tbl[i].e.ill));
            chk($sformatf("tbl%0d_cnt", i), 32'(illegal_cnt), 32'(tbl[i].cnt));
        end
        step(1'b0, 0, 0, 0, 1'b1, 1'b1, acc);
        chk("flush_keeps_cnt", 32'(illegal_cnt), 3);

        // Backpressure: out_ready low 3 cycles, in_valid continuous
        nAcc = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h00221820 + (32'(i) << 11), 32'(i), 32'(i + 10), 1'b0, 1'b0, acc);
            chk($sformatf("stall%0d_ready_sample", i), 32'(out_valid), 1);
            nAcc += int'(acc);
        end
        chk("stall_accepts", 32'(nAcc), 32'(DEPTH));
        chk("stall_head_opr1", out_opr1, 0);
        for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 0, 1'b0, 1'b1, acc);
        chk("drained", 32'(out_valid), 0);

        // Flush with a held entry and a same-cycle input
        step(1'b1, 32'h00221820, 1, 2, 1'b0, 1'b0, acc);
        step(1'b1, 32'h00222004, 3, 4, 1'b1, 1'b0, acc);
        chk("flush_out_valid", 32'(out_valid), 0);
        #1;
        chk("flush_in_ready", 32'(in_ready), 1);
        step(1'b0, 0, 0, 0, 1'b0, 1'b1, acc);
        chk("flush_not_accepted", 32'(out_valid), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            int oi = $urandom_range(0, 13);
            ins = $urandom;
            ins[31:26] = (oi == 13) ? 6'($urandom) : opPick[oi];
            if (ins[31:26] == 0) ins[5:0] = fnPick[$urandom_range(0, 19)];
            rsv = ($urandom % 2) ? $urandom : 32'($urandom_range(0, 40));
            step(($urandom % 4) != 0, ins, rsv, $urandom, ($urandom % 20) == 0,
                 ($urandom % 3) != 0, acc);
        end

        // Counter saturation
        for (int i = 0; i < CNT_MAX + 1; i++) step(1'b1, 32'hFC000000, 0, 0, 1'b0, 1'b1, acc);
        chk("cnt_saturated", 32'(illegal_cnt), 32'(CNT_MAX));

        // Asynchronous reset mid-transfer
        step(1'b1, 32'h00221820, 5, 7, 1'b0, 1'b0, acc);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 0);
        chk("async_rst_cnt", 32'(illegal_cnt), 0);
        chk("async_rst_ctrl", 32'(out_alu_ctrl), 0);
        q.delete();
        modelCnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 32'h00221820, 5, 7, 1'b0, 1'b1, acc);
        step(1'b0, 0, 0, 0, 1'b0, 1'b1, acc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

- Decode-to-execute issue stage for the MIPS31 pipeline: decodes an instruction word plus register-file read data into the 4-bit ALU control code, operand pair and write-back descriptor.
- Registers the result toward the EX stage behind a valid/ready handshake with optional skid buffering.
- It is the producer side of the ALU control interface; every code it emits must mean exactly what the ALU executes.

## Interface
Parameters:
- CNT_W, 16, width of the saturating illegal-instruction counter

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  ID presents an instruction
- in_ready  out  1  stage accepts this cycle
- in_instr  in  32  instruction word
- in_rs_data  in  32  GPR[rs]
- in_rt_data  in  32  GPR[rt]
- flush  in  1  synchronous squash of all held entries
- out_valid  out  1  EX entry valid
- out_ready  in  1  EX consumes this cycle
- out_alu_ctrl  out  4  ALU control code
- out_opr1  out  32  ALU operand 1
- out_opr2  out  32  ALU operand 2
- out_dest  out  5  write-back register
- out_reg_write  out  1  write-back enable
- out_illegal  out  1  undecodable instruction
- illegal_cnt  out  CNT_W  saturating count of accepted illegal instructions

## Operation
ALU control codes:
- 0001 movn; 0010 add; 0011 addu; 0100 sub; 0101 subu; 0110 and; 0111 or; 1000 xor; 1001 nor
- 1010 slt; 1011 sltu; 1100 srl; 1101 sra; 1110 sll; 1111 lui
- 0000 is never a valid operation; it is emitted only for illegal instructions.

Decode and operand rules (imm = in_instr[15:0]):
- R-type (opcode 0), by funct:
  - 0x20 add, 0x21 addu, 0x22 sub, 0x23 subu, 0x24 and, 0x25 or, 0x26 xor, 0x27 nor, 0x2A slt, 0x2B sltu
  - opr1=rs, opr2=rt
- Immediate shifts: sll 0x00, srl 0x02, sra 0x03.
  - opr1 = {27'b0, shamt}, opr2 = rt.
- Variable shifts: sllv 0x04, srlv 0x06, srav 0x07.
  - opr1 = {27'b0, rs[4:0]}; the upper 27 bits are always zeroed, because the ALU shifts by the full 32-bit opr1.
  - opr2 = rt.
- movn 0x0B: code 0001, opr1=rs, opr2=rt. The ALU suppresses the write when opr2==0.
- R-type dest = instr[15:11].
- I-type ops, dest = instr[20:16], opr1 = rs:
  - addi 0x08→0010, addiu 0x09→0011, slti 0x0A→1010, sltiu 0x0B→1011: sign-extended imm.
  - andi 0x0C→0110, ori 0x0D→0111, xori 0x0E→1000: zero-extended imm.
  - lui 0x0F→1111: opr2 = {16'b0, imm}.
  - lw 0x23→0011, sign-extended imm.
- sw 0x2B: code 0011, sign-extended imm, reg_write=0.
- out_reg_write = writes & (dest != 0).
- Any other opcode or funct is illegal:
  - ctrl=0000, opr1=opr2=0, dest=0, reg_write=0, illegal=1.
  - illegal_cnt increments on acceptance and saturates at all-ones. flush does not clear it.

## Timing
- Reset values: out_valid=0, all data outputs 0, illegal_cnt=0.
- in_ready is 1 after reset release.
- Accept when in_valid & in_ready. Latency is 1 cycle from accept to out_valid.
- Output fields are stable while out_valid & !out_ready (no change under backpressure).
- flush:
  - Next edge: out_valid=0 and any skid entry is dropped.
  - A same-cycle input is not accepted; flush has priority.
  - in_ready is 1 the cycle after.
- Simultaneous accept and consume with no skid entry held: the new entry replaces the old one, giving full throughput.
- Reset asserted mid-transfer drops all entries immediately (asynchronous).

## Configuration
- ALU_ISSUE_SKID_EN defined:
  - 2-entry skid buffer; in_ready is a pure register output (= skid entry empty).
  - A stall of out_ready holds one extra entry without dropping.
- ALU_ISSUE_SKID_EN undefined:
  - Single output register; in_ready = !out_valid | out_ready (combinational path from out_ready).
- Decode and ordering are identical in both configurations.

## Structure
- Shared package alu_pkg holds:
  - ALU control code localparams (ALU_MOVN..ALU_LUI, ALU_INVALID=4'b0000)
  - opcode and funct constants
  - a typedef struct for the issue payload (ctrl, opr1, opr2, dest, reg_write, illegal)
- One combinational sub-module, alu_issue_decode (instr, rs, rt → payload). The stage wraps it with handshake and buffering.

## Test plan
- add $3,$1,$2 with rs=5, rt=7: out_alu_ctrl=0010, opr1=5, opr2=7, dest=3, reg_write=1, one cycle after accept.
- sllv with rs=0x00000123, rt=1: opr1=0x00000003, ctrl=1110. sra shamt=31: opr1=31, ctrl=1101.
- andi imm=0x8000: opr2=0x00008000. addi imm=0x8000: opr2=0xFFFF8000. lui imm=0x1234: ctrl=1111, opr2=0x00001234.
- Opcode 0x3F accepted twice: out_illegal=1, ctrl=0000, reg_write=0, illegal_cnt=2. Then flush: illegal_cnt stays 2.
- Hold out_ready=0 for 3 cycles with in_valid=1 continuous (skid enabled): no payload lost or reordered, and in_ready drops after 2 accepts.
- flush together with in_valid=1 while an entry is held: out_valid=0 next cycle, the input is not accepted, and in_ready=1 after.
